// File: rtl/rsfq_splitter_pulse_scheduler_pkg.sv
// Shared types and constants for the RSFQ splitter pulse scheduler.
// The default holdoff is derived from the splitter's critical input time.
package rsfq_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    // Splitter critical time over the harness clock period, rounded up.
    localparam int CRIT_TIME_FS    = 11100;
    localparam int CLK_PERIOD_FS   = 6000;
    localparam int HOLDOFF_DEFAULT = (CRIT_TIME_FS + CLK_PERIOD_FS - 1) / CLK_PERIOD_FS;

    function automatic int clog2_safe(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rsfq_splitter_pulse_scheduler_rr_arbiter.sv
// Round-robin arbiter: first valid source at or after ptr wins, wrapping around.
// Purely combinational; an empty source under ptr is skipped in the same cycle.
module rr_arbiter
    import rsfq_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = clog2_safe(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && valid[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rsfq_splitter_pulse_scheduler.sv
// Shares one splitter input among N_REQ pulse sources: per-source pending counters,
// round-robin service and a forced holdoff gap after every toggle-encoded pulse.
module rsfq_splitter_pulse_scheduler
    import rsfq_sched_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int CNT_W   = 3,
    parameter  int HOLDOFF = HOLDOFF_DEFAULT,
    localparam int IDX_W   = clog2_safe(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             pulse_tgl,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] pend_full,
    output logic [N_REQ-1:0] drop,
    output logic             busy
);

    localparam int              HOLD_W  = clog2_safe(HOLDOFF + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating pending-count update: simultaneous req and grant cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = c;
        if (inc && !dec && c != CNT_MAX) r = c + 1'b1;
        else if (dec && !inc && c != '0) r = c - 1'b1;
        return r;
    endfunction

    function automatic logic req_lost(input logic [CNT_W-1:0] c,
                                      input logic inc, input logic dec);
        return inc && !dec && (c == CNT_MAX);
    endfunction

    sched_state_e                  state_q, state_d;
    logic [HOLD_W-1:0]             hold_q, hold_d;
    logic [IDX_W-1:0]              ptr_q, ptr_next;
    logic [N_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]              valid, win_gnt, drop_d, full_d;
    logic [IDX_W-1:0]              win_idx;
    logic                          fire, any_pend_d, busy_d;

    always_comb begin
        valid = '0;
        for (int i = 0; i < N_REQ; i++) valid[i] = (cnt_q[i] != '0);
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid (valid),
        .ptr   (ptr_q),
        .gnt   (win_gnt),
        .idx   (win_idx)
    );

    assign ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|valid) begin
                    fire = 1'b1;
                    if (HOLDOFF > 0) begin
                        state_d = HOLD;
                        hold_d  = HOLD_W'(HOLDOFF);
                    end
                end
            end
            HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == HOLD_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        drop_d     = '0;
        full_d     = '0;
        any_pend_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i]   = cnt_next(cnt_q[i], req[i], fire && win_gnt[i]);
            drop_d[i]  = req_lost(cnt_q[i], req[i], fire && win_gnt[i]);
            full_d[i]  = (cnt_d[i] == CNT_MAX);
            any_pend_d = any_pend_d | (cnt_d[i] != '0);
        end
    end

    assign busy_d = any_pend_d || (state_d == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            pulse_tgl <= 1'b0;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            pend_full <= '0;
            drop      <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            pend_full <= full_d;
            drop      <= drop_d;
            busy      <= busy_d;
            grant_vld <= fire;
            if (fire) begin
                pulse_tgl <= ~pulse_tgl;
                grant_idx <= win_idx;
                ptr_q     <= ptr_next;
            end
        end
    end

endmodule
